// File: rtl/sfcw_acq_ctrl.sv
// sfcw_acq_ctrl: SFCW receive-path acquisition sequencer.
// For each frequency step: request a synth step, wait for lock, settle,
// capture ADC words, then present one result per step on a valid/ready stream.
// Optional feature macro: ACQ_AVG_EN (averaging over SAMPLES words).
// Without it, a single ADC word is captured per step.
module sfcw_acq_ctrl #(
    parameter int ADC_W      = 14,
    parameter int NUM_STEPS  = 64,
    parameter int SETTLE_CYC = 100,
    parameter int SAMPLES    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ADC_W-1:0] adc_val,
    output logic             step_req,
    input  logic             step_ack,
    output logic [11:0]      step_idx,
    output logic [ADC_W-1:0] res_data,
    output logic [11:0]      res_step,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, STEP, SETTLE, CAPTURE, OUTPUT} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [11:0] LAST_IDX    = 12'(NUM_STEPS - 1);
`ifdef ACQ_AVG_EN
    localparam int          LOG_S       = $clog2(SAMPLES);
    localparam int          ACC_W       = ADC_W + LOG_S;
    localparam logic [15:0] CAP_LAST    = 16'(SAMPLES - 1);
`else
    localparam logic [15:0] CAP_LAST    = 16'd0;
`endif

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        go, settle_done, cap_done, xfer, last_xfer;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and state-derived outputs; abort overrides everything
    always_comb begin
        state_nxt   = state;
        step_req    = 1'b0;
        res_valid   = 1'b0;
        busy        = (state != IDLE);
        go          = 1'b0;
        settle_done = 1'b0;
        cap_done    = 1'b0;
        xfer        = 1'b0;
        last_xfer   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = STEP;
                end
            end
            STEP: begin
                step_req = 1'b1;
                if (step_ack) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    settle_done = 1'b1;
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cnt == CAP_LAST) begin
                    cap_done  = 1'b1;
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    xfer      = 1'b1;
                    last_xfer = (step_idx == LAST_IDX);
                    state_nxt = last_xfer ? IDLE : STEP;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

`ifdef ACQ_AVG_EN
    logic [ACC_W-1:0] acc, acc_sum;
    assign acc_sum = acc + ACC_W'(adc_val);

    // Sample accumulator, cleared as CAPTURE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                acc <= '0;
        else if (settle_done)      acc <= '0;
        else if (state == CAPTURE) acc <= acc_sum;
    end
`else
    logic unused_samples;
    assign unused_samples = ^SAMPLES;
`endif

    // Step index, shared settle/capture counter, result register, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_idx <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_step <= '0;
            done     <= 1'b0;
        end else begin
            done <= last_xfer && !abort;
            if (abort || go)            step_idx <= '0;
            else if (xfer && !last_xfer) step_idx <= step_idx + 12'd1;
            // cnt reads zero on the first cycle of SETTLE and of CAPTURE
            if ((state == SETTLE && !settle_done) || state == CAPTURE) cnt <= cnt + 16'd1;
            else                                                       cnt <= '0;
            if (cap_done) begin
                res_step <= step_idx;
`ifdef ACQ_AVG_EN
                res_data <= acc_sum[ACC_W-1:LOG_S];
`else
                res_data <= adc_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sfcw_acq_ctrl.sv
// Self-checking bench for sfcw_acq_ctrl. The reference is a per-step timeline:
// the bench chooses when it acks and accepts, derives from those choices which
// cycles step_req/res_valid must be high in, and averages the words it drove
// in the capture window to get the expected result.
module tb_sfcw_acq_ctrl;

    localparam int ADC_W = 14;
    localparam int NS    = 4;
    localparam int SC    = 3;
    localparam int SMP   = 4;
`ifdef ACQ_AVG_EN
    localparam int CAP   = SMP;
`else
    localparam int CAP   = 1;
`endif

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             start = 1'b0, abort = 1'b0, step_ack = 1'b0, res_ready = 1'b0;
    logic [ADC_W-1:0] adc_val = '0;
    logic             step_req, res_valid, busy, done;
    logic [11:0]      step_idx, res_step;
    logic [ADC_W-1:0] res_data;

    int n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;

    sfcw_acq_ctrl #(.ADC_W(ADC_W), .NUM_STEPS(NS), .SETTLE_CYC(SC), .SAMPLES(SMP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .adc_val(adc_val),
        .step_req(step_req), .step_ack(step_ack), .step_idx(step_idx),
        .res_data(res_data), .res_step(res_step), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic vld,
                           input logic bsy, input int idx);
        chk({tag, ".req"},  step_req,  req);
        chk({tag, ".vld"},  res_valid, vld);
        chk({tag, ".busy"}, busy,      bsy);
        chk({tag, ".done"}, done,      1'b0);
        if (idx >= 0) chk({tag, ".idx"}, step_idx, idx);
    endtask

    function automatic logic rb(input int n);
        return ($urandom_range(n - 1, 0) == 0);
    endfunction

    function automatic logic [ADC_W-1:0] rv();
        return ADC_W'($urandom);
    endfunction

    // ADC word driven on capture sample number idx
    function automatic logic [ADC_W-1:0] pat(input int mode, input int idx);
        case (mode)
            1: return 14'h1234;
            2: begin
                case (idx % 4)
                    0:       return 14'd1;
                    1:       return 14'd2;
                    2:       return 14'd3;
                    default: return 14'd5;
                endcase
            end
            3: return 14'h3FFF;
            default: return rv();
        endcase
    endfunction

    // Drive one cycle's inputs; the DUT samples them at the next rising edge
    task automatic cycle(input logic st, input logic ab, input logic ack,
                         input logic rdy, input logic [ADC_W-1:0] a);
        start = st; abort = ab; step_ack = ack; res_ready = rdy; adc_val = a;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_sweep(input int mode, input int abort_k, input int reset_k,
                             input int stall_k, input int bp_k);
        int d, hold, sum, ab_i;
        logic [ADC_W-1:0] v;
        logic ab;
        chk_ctl("idle", 1'b0, 1'b0, 1'b0, -1);
        cycle(1'b1, 1'b0, rb(2), rb(2), rv());
        for (int k = 0; k < NS; k++) begin
            d = (k == stall_k) ? 50 : $urandom_range(3, 0);
            for (int i = 0; i <= d; i++) begin
                chk_ctl("step", 1'b1, 1'b0, 1'b1, k);
                cycle(rb(8), 1'b0, (i == d), rb(2), rv());
            end
            sum  = 0;
            ab_i = SC + 1 + CAP / 2;
            for (int i = 1; i <= SC + CAP; i++) begin
                chk_ctl((i <= SC) ? "settle" : "capture", 1'b0, 1'b0, 1'b1, k);
                if (k == reset_k && i == 2) begin
                    start = 1'b0; abort = 1'b0; step_ack = 1'b0; res_ready = 1'b0;
                    #2 rst_n = 1'b0;
                    #1;
                    chk("arst.req",   step_req,  1'b0);
                    chk("arst.vld",   res_valid, 1'b0);
                    chk("arst.busy",  busy,      1'b0);
                    chk("arst.done",  done,      1'b0);
                    chk("arst.idx",   step_idx,  0);
                    chk("arst.data",  res_data,  0);
                    chk("arst.rstep", res_step,  0);
                    @(posedge clk); #1;
                    cyc++;
                    rst_n = 1'b1;
                    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0, 0);
                    return;
                end
                v  = (i > SC) ? pat(mode, i - SC - 1) : rv();
                if (i > SC) sum += int'(v);
                ab = (k == abort_k && i == ab_i);
                cycle(ab | rb(8), ab, rb(3), rb(2), v);
                if (ab) begin
                    for (int j = 0; j < 3; j++) begin
                        chk_ctl("abort", 1'b0, 1'b0, 1'b0, 0);
                        cycle(1'b0, 1'b0, rb(2), rb(2), rv());
                    end
                    return;
                end
            end
            hold = (k == bp_k) ? 10 : ((mode == 0) ? $urandom_range(3, 0) : 0);
            for (int i = 0; i <= hold; i++) begin
                chk_ctl("out", 1'b0, 1'b1, 1'b1, k);
                chk("res_data", res_data, sum / CAP);
                chk("res_step", res_step, k);
                cycle(rb(8), 1'b0, rb(2), (i == hold), rv());
            end
        end
        chk("done",      done,     1'b1);
        chk("done.busy", busy,     1'b0);
        chk("done.req",  step_req, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rv());
        chk("done.pulse", done, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req",   step_req,  1'b0);
        chk("rst.vld",   res_valid, 1'b0);
        chk("rst.busy",  busy,      1'b0);
        chk("rst.done",  done,      1'b0);
        chk("rst.idx",   step_idx,  0);
        chk("rst.data",  res_data,  0);
        chk("rst.rstep", res_step,  0);
        rst_n = 1'b1;
        run_sweep(1, -1, -1, -1, -1);   // constant 0x1234
        run_sweep(2, -1, -1, -1, -1);   // 1,2,3,5 truncating average
        run_sweep(3, -1, -1, -1, -1);   // full-scale input, no wrap
        run_sweep(0, -1, -1,  1,  2);   // lock stall on step 1, backpressure on step 2
        run_sweep(0,  2, -1, -1, -1);   // abort in capture of step 2
        run_sweep(0, -1,  1, -1, -1);   // async reset during settle
        repeat (4) run_sweep(0, -1, -1, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
